send_bram_stream: RTL
=====================

Name: send_bram_stream

Overview:
- Reads a block of N complex samples out of a BRAM port and transmits them as an AXI-Stream master. Each sample is {im[31:16], re[15:0]}, signed 16-bit parts.
- It is the transmit-side counterpart of the F2 stream-to-BRAM loader. The controller uses it to stream correlation/FFT buffers out of BRAM into downstream FFT/IFFT cores or the DMA.
- Handles BRAM read latency and full AXIS backpressure with no lost or duplicated samples.

Parameters:
- BRAM_LATENCY, 1, BRAM read latency in cycles from bram_en/bram_addr to valid bram_rdata. Legal values are 1..3.
- ADDR_W, 13, address and length width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- N  in  ADDR_W  number of samples to send. Sampled on an accepted start.
- start  in  1  one-cycle request. Accepted only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.
- bram_addr  out  ADDR_W  BRAM read address.
- bram_en  out  1  BRAM read enable. One read is issued per high cycle.
- bram_rdata  in  32  BRAM read data, valid BRAM_LATENCY cycles after bram_en.
- m_tdata  out  32  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  marks the sample at address N-1.

Behaviour:
- Clock aclk; reset aresetn, synchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, bram_en=0, bram_addr=0, m_tvalid=0, m_tlast=0, m_tdata=0. The FIFO is emptied and all in-flight tags are cleared.
- Reset mid-transfer aborts immediately. Late BRAM data is discarded and no done pulse is issued.
- FSM states:
  - IDLE: on start with N!=0, latch N, clear the issue and send counters, go to RUN. On start with N==0, pulse done on the next cycle, stay in IDLE, emit no beats. start is ignored while busy.
  - RUN: issue reads at ascending addresses 0..N-1. When the read at N-1 is issued, go to DRAIN.
  - DRAIN: no reads. When the beat with tlast is accepted (m_tvalid & m_tready), go to IDLE and pulse done on the following cycle.
- Read issue:
  - Output FIFO depth D = BRAM_LATENCY+2.
  - bram_en=1 in RUN when fifo_count + inflight < D.
  - inflight is the number of reads issued whose data has not yet been written to the FIFO. It is tracked with a BRAM_LATENCY-deep valid/last tag shift register.
  - bram_addr increments after each issued read.
  - This credit rule guarantees the FIFO never overflows, so returning data is always written without a stall.
- Output:
  - m_tdata, m_tvalid and m_tlast come from FIFO head registers.
  - A beat stays stable while m_tvalid & !m_tready (AXIS rule).
  - Simultaneous FIFO push and pop in the same cycle is legal and keeps the count.
- Latency: with start at cycle 0 and m_tready held high, the first m_tvalid is at cycle BRAM_LATENCY+2. After that, one beat per cycle with no bubbles. done pulses one cycle after the tlast handshake.
- Throughput with m_tready held low: issue stops after D outstanding samples. Streaming resumes without gaps once ready returns.
- N=1: a single beat with tlast=1.
- N=2^ADDR_W-1 (8191): addresses run 0..8190 with no wrap.

Optional Feature:
- Macro: SEND_BRAM_CONJ_EN.
- Defined: output im = -bram im (two's complement, 16-bit). -32768 maps to -32768 (wraps, no saturation). re passes unchanged. Negation is applied on FIFO write, so latency is unchanged.
- Undefined: m_tdata = bram_rdata, bit-exact.

Test Plan:
- BRAM preloaded with mem[i]={i+100,i}, N=8, m_tready=1, BRAM_LATENCY=1 -> 8 beats re=0..7, im=100..107 on consecutive cycles. First valid 3 cycles after start, tlast only on beat 7, done 1 cycle later, busy low after done.
- Same data, N=16, m_tready toggled randomly 50% -> exactly 16 beats in order, no duplicates. tdata/tlast stable during stalls. bram_en never issues with more than 3 outstanding (fifo_count + inflight never exceeds D=3).
- N=0 start -> done pulse next cycle, no m_tvalid, no bram_en. N=1 -> single beat addr 0 with tlast=1.
- BRAM_LATENCY=3, N=5, m_tready low for 10 cycles, then high -> at most 5 reads issued while stalled, then 5 beats back-to-back, correct order.
- aresetn low for 1 cycle while 4 of 8 beats sent -> all outputs 0 the next cycle, no done pulse. A new start with N=3 then sends addresses 0..2 correctly.
- With SEND_BRAM_CONJ_EN defined, mem[0]={16'h8000,16'h0005} and mem[1]={16'h0001,16'hFFFF} -> beats 0x80000005 and 0xFFFFFFFF.

Source files
------------

// File: rtl/send_bram_stream.sv
// rtl/send_bram_stream.sv - streams N BRAM samples out as AXIS beats; define SEND_BRAM_CONJ_EN to negate the im half
module send_bram_stream #(
    parameter int BRAM_LATENCY = 1,
    parameter int ADDR_W       = 13
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] N,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [31:0]       bram_rdata,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast
);
    localparam int D  = BRAM_LATENCY + 2;
    localparam int PW = $clog2(D);
    localparam int CW = $clog2(D + 1);
    localparam int IW = CW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0]     n_reg, issue_addr;
    logic [BRAM_LATENCY-1:0] tag_v, tag_last;
    logic [31:0]           fifo_data [2**PW];
    logic [2**PW-1:0]      fifo_last;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [IW-1:0]         inflight;
    logic                  done_r, done_nxt;
    logic                  issue_last, push, pop, accept;
    logic [31:0]           wdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) inflight = inflight + IW'(tag_v[i]);
    end

    // Credit rule: a read is only issued if its data is sure to find a FIFO slot.
    assign bram_en    = (state == RUN) && ((IW'(fifo_count) + inflight) < IW'(D));
    assign bram_addr  = issue_addr;
    assign issue_last = (issue_addr == n_reg - ADDR_W'(1));
    assign accept     = (state == IDLE) && start && (N != '0);
    assign push       = tag_v[BRAM_LATENCY-1];
    assign m_tvalid   = (fifo_count != '0);
    assign m_tdata    = fifo_data[rd_ptr];
    assign m_tlast    = m_tvalid & fifo_last[rd_ptr];
    assign pop        = m_tvalid & m_tready;
    assign busy       = (state != IDLE);
    assign done       = done_r;

`ifdef SEND_BRAM_CONJ_EN
    assign wdata = {16'd0 - bram_rdata[31:16], bram_rdata[15:0]};
`else
    assign wdata = bram_rdata;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (N != '0) state_nxt = RUN;
                    else         done_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (bram_en && issue_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && m_tlast) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            n_reg      <= '0;
            issue_addr <= '0;
            tag_v      <= '0;
            tag_last   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_last  <= '0;
            for (int i = 0; i < 2**PW; i++) fifo_data[i] <= '0;
        end else begin
            if (accept) begin
                n_reg      <= N;
                issue_addr <= '0;
            end else if (bram_en) begin
                issue_addr <= issue_addr + ADDR_W'(1);
            end
            // Tags travel alongside the BRAM pipeline so returning data knows it is valid/last.
            tag_v[0]    <= bram_en;
            tag_last[0] <= bram_en & issue_last;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                tag_v[i]    <= tag_v[i-1];
                tag_last[i] <= tag_last[i-1];
            end
            if (push) begin
                fifo_data[wr_ptr] <= wdata;
                fifo_last[wr_ptr] <= tag_last[BRAM_LATENCY-1];
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end
endmodule
